// File: rtl/trigger_window_reader.sv
// trigger_window_reader: circular sample buffer that captures a pre/post-trigger window and streams it out
// Ports:
//    clk, rst                    system clock, synchronous active-high reset
//    pre_samples, post_samples   window lengths, latched whenever ARMING is entered
//    d                           input sample stream, one sample per clk
//    trig                        trigger strobe, honoured only while armed
//    m_data, m_valid, m_ready    window readout stream, oldest sample first, with backpressure
//    m_last                      final beat of the window
//    armed, busy                 state flags (ARMED; POST or READOUT)
//    trig_missed                 one-cycle pulse for a trigger that arrived outside ARMED
module trigger_window_reader #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [$clog2(DEPTH):0] pre_samples,
   input  logic [$clog2(DEPTH):0] post_samples,
   input  logic [WIDTH-1:0]       d,
   input  logic                   trig,
   output logic [WIDTH-1:0]       m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic                   m_last,
   output logic                   armed,
   output logic                   busy,
   output logic                   trig_missed
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] LDEPTH = CW'(DEPTH);

   typedef enum logic [1:0] {ARMING, ARMED, POST, READOUT} state_t;

   state_t           r_state;
   logic [AW-1:0]    r_wr_pos;
   logic [AW-1:0]    r_rd_addr;
   logic [CW-1:0]    r_fill;
   logic [CW-1:0]    r_pre_e;
   logic [CW-1:0]    r_post_e;
   logic [CW-1:0]    r_post_cnt;
   logic [CW-1:0]    r_left;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_q;
   logic             r_qv;
   logic             r_qlast;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_last;
   logic             r_missed;

   logic [CW-1:0]    w_pre_e;
   logic [CW-1:0]    w_room;
   logic [CW-1:0]    w_post_c;
   logic [CW-1:0]    w_post_e;
   logic             w_we;
   logic             w_adv;
   logic             w_move;
   logic             w_rd;
   logic             w_done;

   // effective window lengths, clamped so the whole window fits in the buffer
   assign w_pre_e  = (pre_samples > LDEPTH) ? LDEPTH : pre_samples;
   assign w_room   = LDEPTH - w_pre_e;
   assign w_post_c = (post_samples > w_room) ? w_room : post_samples;
   assign w_post_e = (w_pre_e == '0 && w_post_c == '0) ? CW'(1) : w_post_c;

   // a pre-only window must not overwrite its own oldest sample on the trigger cycle
   assign w_we   = (r_state == ARMING) || (r_state == POST) ||
                   ((r_state == ARMED) && !(trig && r_post_e == '0));
   // output register takes a new beat when empty or when its beat is accepted;
   // a RAM read is issued only if the prefetch slot is free or draining this cycle
   assign w_adv  = !r_valid || m_ready;
   assign w_move = r_qv && w_adv;
   assign w_rd   = (r_state == READOUT) && (r_left != '0) && (!r_qv || w_move);
   assign w_done = r_valid && m_ready && r_last;

   always_ff @(posedge clk) begin
      if (w_we) r_mem[r_wr_pos] <= d;
      if (w_rd) r_q <= r_mem[r_rd_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ARMING;
         r_wr_pos   <= '0;
         r_rd_addr  <= '0;
         r_fill     <= '0;
         r_pre_e    <= w_pre_e;
         r_post_e   <= w_post_e;
         r_post_cnt <= '0;
         r_left     <= '0;
         r_qv       <= 1'b0;
         r_qlast    <= 1'b0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_last     <= 1'b0;
         r_missed   <= 1'b0;
      end else begin
         r_missed <= trig && (r_state != ARMED);
         if (w_we) begin
            r_wr_pos <= r_wr_pos + AW'(1);
            if (r_fill != LDEPTH) r_fill <= r_fill + CW'(1);
         end
         if (w_rd) begin
            r_rd_addr <= r_rd_addr + AW'(1);
            r_left    <= r_left - CW'(1);
            r_qlast   <= (r_left == CW'(1));
         end
         if (w_rd) r_qv <= 1'b1;
         else if (w_move) r_qv <= 1'b0;
         if (w_adv) begin
            r_valid <= r_qv;
            r_data  <= r_q;
            r_last  <= r_qv && r_qlast;
         end
         case (r_state)
            ARMING: if (r_fill >= r_pre_e) r_state <= ARMED;
            ARMED: if (trig) begin
               r_rd_addr  <= r_wr_pos - r_pre_e[AW-1:0];
               r_left     <= r_pre_e + r_post_e;
               r_post_cnt <= CW'(1);
               r_state    <= (r_post_e <= CW'(1)) ? READOUT : POST;
            end
            POST: begin
               r_post_cnt <= r_post_cnt + CW'(1);
               if (r_post_cnt + CW'(1) == r_post_e) r_state <= READOUT;
            end
            READOUT: if (w_done) begin
               r_state  <= ARMING;
               r_fill   <= '0;
               r_pre_e  <= w_pre_e;
               r_post_e <= w_post_e;
            end
            default: r_state <= ARMING;
         endcase
      end
   end

   assign m_data      = r_data;
   assign m_valid     = r_valid;
   assign m_last      = r_last;
   assign armed       = (r_state == ARMED);
   assign busy        = (r_state == POST) || (r_state == READOUT);
   assign trig_missed = r_missed;
endmodule

// File: tb/tb_trigger_window_reader.sv
// tb_trigger_window_reader: directed self-checking bench for trigger_window_reader (DEPTH=16, WIDTH=8)
module tb_trigger_window_reader;
   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] pre;
   logic [4:0] post;
   logic [7:0] d;
   logic       trig;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       m_last;
   logic       armed;
   logic       busy;
   logic       trig_missed;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] t;
   int         got;
   int         c;

   trigger_window_reader #(.DEPTH(16), .WIDTH(8)) dut (
      .clk(clk), .rst(rst), .pre_samples(pre), .post_samples(post), .d(d), .trig(trig),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .armed(armed), .busy(busy), .trig_missed(trig_missed)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // d advances by one per clock, so every posedge writes a new consecutive value
   task automatic step();
      @(posedge clk);
      #1;
      d = d + 8'd1;
   endtask

   task automatic fire(output logic [7:0] tv);
      tv = d;
      trig = 1'b1;
      step();
      trig = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic wait_armed(input string tag);
      int n = 0;
      while (!armed && n < 40) begin
         step();
         n++;
      end
      chk(tag, armed, 1);
   endtask

   // with pre_e=4: still unarmed after 4 written samples, armed one cycle later
   task automatic rearm(input string tag);
      for (int i = 0; i < 4; i++) begin
         chk({tag, " no beat"}, m_valid, 0);
         step();
      end
      chk({tag, " armed low"}, armed, 0);
      step();
      chk({tag, " armed high"}, armed, 1);
   endtask

   task automatic collect(input string tag, input int n, input logic [7:0] first, input bit bp);
      logic [5:0] pat = 6'b101001;
      int         k = 0;
      int         cyc = 0;
      logic       hv = 1'b0;
      logic [7:0] hd = '0;
      logic       hl = 1'b0;
      while (k < n && cyc < 300) begin
         m_ready = bp ? pat[3'(cyc % 6)] : 1'b1;
         if (hv) begin
            chk({tag, " hold valid"}, m_valid, 1);
            chk({tag, " hold data"}, m_data, hd);
            chk({tag, " hold last"}, m_last, hl);
         end
         if (m_valid && m_ready) begin
            chk({tag, " data"}, m_data, first + 8'(k));
            chk({tag, " last"}, m_last, (k == n - 1));
            k++;
         end
         hv = m_valid && !m_ready;
         hd = m_data;
         hl = m_last;
         step();
         cyc++;
      end
      chk({tag, " beats"}, k, n);
      chk({tag, " valid after last"}, m_valid, 0);
      m_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1; trig = 1'b0; m_ready = 1'b1; d = 8'd0; pre = 5'd4; post = 5'd3;
      repeat (3) step();
      chk("reset m_valid", m_valid, 0);
      chk("reset m_last", m_last, 0);
      chk("reset armed", armed, 0);
      chk("reset busy", busy, 0);
      chk("reset trig_missed", trig_missed, 0);
      rst = 1'b0;
      rearm("basic");
      while (d != 8'd20) step();
      chk("basic armed at trig", armed, 1);
      fire(t);
      chk("basic busy", busy, 1);
      chk("basic armed after trig", armed, 0);
      collect("basic", 7, 8'd16, 1'b0);

      rearm("rearm");
      fire(t);
      step();
      step();
      m_ready = 1'b0;
      trig = 1'b1;
      step();
      trig = 1'b0;
      chk("missed pulse", trig_missed, 1);
      chk("missed not armed", armed, 0);
      step();
      chk("missed pulse end", trig_missed, 0);
      collect("backpressure", 7, t - 8'd4, 1'b1);
      rearm("second rearm");
      fire(t);
      collect("fresh", 7, t - 8'd4, 1'b0);

      pre = 5'd10; post = 5'd6;
      do_reset();
      repeat (19) step();
      chk("wrap armed", armed, 1);
      fire(t);
      collect("wrap", 16, t - 8'd10, 1'b0);

      pre = 5'd20; post = 5'd5;
      do_reset();
      wait_armed("clamp armed");
      fire(t);
      chk("clamp busy", busy, 1);
      collect("clamp", 16, t - 8'd16, 1'b0);

      pre = 5'd0; post = 5'd0;
      do_reset();
      wait_armed("zero armed");
      fire(t);
      collect("zero", 1, t, 1'b0);

      pre = 5'd4; post = 5'd3;
      do_reset();
      wait_armed("rst armed");
      fire(t);
      got = 0;
      c = 0;
      while (got < 3 && c < 50) begin
         if (m_valid) begin
            chk("rst partial data", m_data, t - 8'd4 + 8'(got));
            got++;
         end
         step();
         c++;
      end
      chk("rst partial beats", got, 3);
      rst = 1'b1;
      step();
      chk("rst m_valid", m_valid, 0);
      chk("rst m_last", m_last, 0);
      chk("rst armed", armed, 0);
      chk("rst busy", busy, 0);
      rst = 1'b0;
      rearm("post rst");
      fire(t);
      collect("after rst", 7, t - 8'd4, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
